fetch_stage: RTL and testbench

//   IF stage of the 5-stage RV32I pipeline, directly upstream of instruction memory and feeding decode.

---
 rtl/fetch_stage_pkg.sv | 10 +
 rtl/fetch_stage_if_id_reg.sv | 38 +++
 rtl/fetch_stage.sv | 82 ++++++++
 tb/tb_fetch_stage.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the IF stage: datapath width, the canonical NOP
// (addi x0,x0,0) and the default reset vector.
package fetch_stage_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR            = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

endpackage : fetch_stage_pkg

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: a flush (or reset) inserts a bubble, a stall holds,
// otherwise the fetched entry is captured. Faulted entries carry a NOP word.
module if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            fault_in,
    input  logic [XLEN-1:0] instr_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] pc_plus4_in,
    output logic [XLEN-1:0] instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_plus4_d,
    output logic            valid_d,
    output logic            fault_d
);

    // Bubble and reset share the same contents; flush outranks stall.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            instr_d    <= NOP_INSTR;
            pc_d       <= '0;
            pc_plus4_d <= '0;
            valid_d    <= 1'b0;
            fault_d    <= 1'b0;
        end else if (!stall) begin
            instr_d    <= fault_in ? NOP_INSTR : instr_in;
            pc_d       <= pc_in;
            pc_plus4_d <= pc_plus4_in;
            valid_d    <= 1'b1;
            fault_d    <= fault_in;
        end
    end

endmodule : if_id_reg

// File: rtl/fetch_stage.sv
// IF stage of the 5-stage RV32I pipeline: PC register, next-PC selection and
// IF/ID capture. Define FETCH_FAULT_EN to flag misaligned/out-of-range fetches.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter int unsigned     IMEM_WORDS   = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_f,
    input  logic            stall_d,
    input  logic            flush_d,
    input  logic            pc_src_e,
    input  logic [XLEN-1:0] pc_target_e,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_plus4_d,
    output logic            valid_d,
    output logic            fault_d,
    output logic [XLEN-1:0] fetch_count
);

    if (IMEM_WORDS == 0 || IMEM_WORDS > 32'h4000_0000) begin : g_bad_depth
        $error("fetch_stage: IMEM_WORDS must be in 1..2^30");
    end

    logic [XLEN-1:0] pc_f;
    logic [XLEN-1:0] pc_plus4_f;
    logic            bubble_d;
    logic            load_d;
    logic            fault_f;

    assign pc_plus4_f = pc_f + 32'd4;
    assign imem_addr  = pc_f;
    assign bubble_d   = flush_d | pc_src_e;
    assign load_d     = !bubble_d && !stall_d;

`ifdef FETCH_FAULT_EN
    assign fault_f = (pc_f[1:0] != 2'b00) || ({2'b00, pc_f[31:2]} >= IMEM_WORDS);
`else
    assign fault_f = 1'b0;
`endif

    // A resolved redirect wins even over a hazard-unit stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_f <= RESET_VECTOR;
        end else if (pc_src_e) begin
            pc_f <= pc_target_e;
        end else if (!stall_f) begin
            pc_f <= pc_plus4_f;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count <= '0;
        end else if (load_d) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end

    if_id_reg u_if_id_reg (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall_d),
        .flush       (bubble_d),
        .fault_in    (fault_f),
        .instr_in    (imem_rdata),
        .pc_in       (pc_f),
        .pc_plus4_in (pc_plus4_f),
        .instr_d     (instr_d),
        .pc_d        (pc_d),
        .pc_plus4_d  (pc_plus4_d),
        .valid_d     (valid_d),
        .fault_d     (fault_d)
    );

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, sequential fetch, stalls, redirect,
// flush, PC wrap, optional fetch fault and mid-stream reset.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_f;
    logic        stall_d;
    logic        flush_d;
    logic        pc_src_e;
    logic [31:0] pc_target_e;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic        valid_d;
    logic        fault_d;
    logic [31:0] fetch_count;

    logic [31:0] imem [0:1023];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign imem_rdata = imem[imem_addr[11:2]];

    fetch_stage #(
        .RESET_VECTOR (32'h0000_0000),
        .IMEM_WORDS   (1024)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall_f     (stall_f),
        .stall_d     (stall_d),
        .flush_d     (flush_d),
        .pc_src_e    (pc_src_e),
        .pc_target_e (pc_target_e),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .instr_d     (instr_d),
        .pc_d        (pc_d),
        .pc_plus4_d  (pc_plus4_d),
        .valid_d     (valid_d),
        .fault_d     (fault_d),
        .fetch_count (fetch_count)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one cycle of control inputs, then sample 1 time unit after the edge.
    task automatic applyStimulus(input logic r, input logic sf, input logic sd,
                                 input logic fl, input logic ps, input logic [31:0] tgt);
        rst         = r;
        stall_f     = sf;
        stall_d     = sd;
        flush_d     = fl;
        pc_src_e    = ps;
        pc_target_e = tgt;
        @(posedge clk);
        #1;
    endtask

    task automatic checkAll(input string tag, input logic [31:0] e_instr, input logic [31:0] e_pc,
                            input logic [31:0] e_pc4, input logic e_valid, input logic e_fault,
                            input logic [31:0] e_count, input logic [31:0] e_addr);
        checkOutput({tag, ".instr"},  instr_d,            e_instr);
        checkOutput({tag, ".pc"},     pc_d,               e_pc);
        checkOutput({tag, ".pc4"},    pc_plus4_d,         e_pc4);
        checkOutput({tag, ".valid"},  {31'd0, valid_d},   {31'd0, e_valid});
        checkOutput({tag, ".fault"},  {31'd0, fault_d},   {31'd0, e_fault});
        checkOutput({tag, ".count"},  fetch_count,        e_count);
        checkOutput({tag, ".addr"},   imem_addr,          e_addr);
    endtask

    function automatic logic [31:0] word(input int idx);
        return 32'hC0DE_0000 + 32'(idx);
    endfunction

    initial begin
        for (int i = 0; i < 1024; i++) imem[i] = word(i);
        rst = 1'b1; stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
        pc_src_e = 1'b0; pc_target_e = 32'h0;

        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkAll("reset", NOP, 0, 0, 0, 0, 0, 32'h0);

        applyStimulus(0, 0, 0, 0, 0, 0);
        checkAll("seq0", word(0), 32'h0, 32'h4, 1, 0, 1, 32'h4);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkAll("seq1", word(1), 32'h4, 32'h8, 1, 0, 2, 32'h8);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkAll("seq2", word(2), 32'h8, 32'hC, 1, 0, 3, 32'hC);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 1, 0, 0, 0);
            checkAll("stall", word(2), 32'h8, 32'hC, 1, 0, 3, 32'hC);
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkAll("resume", word(3), 32'hC, 32'h10, 1, 0, 4, 32'h10);

        applyStimulus(0, 1, 0, 0, 1, 32'h40);
        checkAll("redir", NOP, 0, 0, 0, 0, 4, 32'h40);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkAll("redir_word", word(16), 32'h40, 32'h44, 1, 0, 5, 32'h44);

        applyStimulus(0, 0, 0, 1, 0, 0);
        checkAll("flush", NOP, 0, 0, 0, 0, 5, 32'h48);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkAll("post_flush", word(18), 32'h48, 32'h4C, 1, 0, 6, 32'h4C);

        applyStimulus(0, 1, 0, 0, 0, 0);
        checkAll("sf_only0", word(19), 32'h4C, 32'h50, 1, 0, 7, 32'h4C);
        applyStimulus(0, 1, 0, 0, 0, 0);
        checkAll("sf_only1", word(19), 32'h4C, 32'h50, 1, 0, 8, 32'h4C);

        applyStimulus(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        checkAll("wrap_redir", NOP, 0, 0, 0, 0, 8, 32'hFFFF_FFFC);
        applyStimulus(0, 0, 0, 0, 0, 0);
`ifdef FETCH_FAULT_EN
        checkAll("wrap", NOP, 32'hFFFF_FFFC, 32'h0, 1, 1, 9, 32'h0);
`else
        checkAll("wrap", word(1023), 32'hFFFF_FFFC, 32'h0, 1, 0, 9, 32'h0);
`endif

        applyStimulus(0, 0, 0, 0, 1, 32'h42);
        checkAll("mis_redir", NOP, 0, 0, 0, 0, 9, 32'h42);
        applyStimulus(0, 0, 0, 0, 0, 0);
`ifdef FETCH_FAULT_EN
        checkAll("misalign", NOP, 32'h42, 32'h46, 1, 1, 10, 32'h46);
`else
        checkAll("misalign", word(16), 32'h42, 32'h46, 1, 0, 10, 32'h46);
`endif

        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 0, 0);
        checkAll("mid_reset", NOP, 0, 0, 0, 0, 0, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkAll("after_reset", word(0), 32'h0, 32'h4, 1, 0, 1, 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fetch_stage
